uart_tx_module: RTL and testbench
=================================

# uart_tx_module

UART transmitter for the register-bus side of the design: the outbound counterpart to the UART receive path. Buffers bytes written by the core in a small FIFO and serialises each one onto `Tx` as start bit, 8 data bits LSB first, optional even-parity bit, and stop bit. Bit timing is derived from the same 16x-baud oversample rate the receiver uses, presented here as a one-cycle enable on the system clock.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, minimum 2.
- `OVERSAMPLE`, 16: ticks per bit.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-`clk` pulse at 16x baud.
- `data_in`  in  8  byte to send.
- `data_in_valid`  in  1  write request.
- `data_in_ready`  out  1  FIFO can accept a byte.
- `Tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  frame in progress, or FIFO non-empty.

## Operation
- **Write:** a byte is accepted on a `clk` edge when `data_in_valid && data_in_ready`.
  - `data_in_ready = !full`, computed from the registered count.
  - A push while full is dropped and raises no error.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `Tx` = 1.
  - If the FIFO is non-empty, pop one byte into the shift register, clear the tick counter and go to START.
  - The pop does not wait for `tick`.
- **Bit timing:**
  - Each state counts `tick` pulses in a 4-bit counter.
  - The bit ends on the cycle of its 16th tick.
  - On that cycle the counter wraps to 0 and the FSM advances.
- **START:** `Tx` = 0.
- **DATA:**
  - `Tx` = shift[0].
  - Shift right after each bit.
  - A 3-bit index counts 0..7; leave after index 7.
- **PARITY** (only with the macro): `Tx` = XOR of the 8 data bits (even parity).
- **STOP:**
  - `Tx` = 1.
  - After 16 ticks, return to IDLE.
  - If the FIFO is non-empty, the next byte is popped on the following cycle, so frames are back-to-back with no extra idle bits.
- **Simultaneous push and pop:** count is unchanged and both operations take effect.
- **Push into an empty FIFO:** the FSM sees the byte the cycle after the push.
- **Pointers:** wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- **`tx_busy`** = (state != IDLE) || !empty.

## Timing
- **Reset values:** `Tx`=1, `tx_busy`=0, `data_in_ready`=1, state=IDLE, FIFO empty, counters 0.
- **Reset mid-frame:** `Tx` goes to 1 asynchronously, the FIFO is flushed and the partial frame is lost.
- **Latency:** a push at edge N makes `Tx` fall at edge N+2 when the block is idle.
- **Frame length:** 176 ticks with parity, 160 ticks without.
- **`tick` held low:** the current bit is held indefinitely.
- **`tick` on the pop cycle:** ignored. It is not counted toward the start bit.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists.
  - The frame is 11 bits: start, 8 data, parity, stop.
  - This matches the receiver's 9-bit frame.
- Undefined:
  - The PARITY state and its logic are removed.
  - DATA goes directly to STOP.
  - The frame is 10 bits.

## Structure
- **Package `uart_pkg`:**
  - state enum `tx_state_t`.
  - `DATA_BITS`=8.
  - `OVERSAMPLE_DEF`=16.
  - `IDLE_LEVEL`=1'b1.
- **Sub-module `uart_tx_fifo`:** synchronous FIFO with push, pop, `full`, `empty` and `rdata`. Read data is valid combinationally while not empty.
- **FSM, shifter and counters** live in `uart_tx_module`.

## Test plan
- **Reset:** assert `rst` -> `Tx`=1, `tx_busy`=0, `data_in_ready`=1.
- **Single byte, parity on:** push 0xA5 with `tick` every 4 clks.
  - Expect `Tx` = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop).
  - Each bit lasts 16 ticks; 176 ticks in total; `tx_busy` falls after stop.
- **Burst into idle block:** push 6 bytes on consecutive cycles (depth 4).
  - Expect 5 accepted (1 in the shifter, 4 in the FIFO) and `data_in_ready`=0 on the 6th cycle.
  - Frames go out in order, back-to-back, with no idle gap.
- **Reset mid-frame:** assert `rst` during data bit 3.
  - Expect `Tx`=1 immediately and FIFO empty.
  - After release, a push of 0x3C produces a clean frame.
- **Parity off (macro undefined):** push 0x00.
  - Expect `Tx` = 0 for 9 bits then 1 for 1 bit; 160 ticks in total.
- **Stalled tick:** push 0xFF and hold `tick`=0.
  - Expect `Tx`=0 held and `tx_busy`=1 indefinitely.
  - Resume `tick` -> the frame completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   DATA_BITS      = 8;
    localparam int   OVERSAMPLE_DEF = 16;
    localparam logic IDLE_LEVEL     = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the transmitter; read data is
// presented combinationally from the head entry whenever not empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data LSB first,
// optional even parity (UART_TX_PARITY_EN), stop; bit time = OVERSAMPLE ticks.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       Tx,
    output logic       tx_busy
);

    localparam int                CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]     TICK_END = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]        LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t              state;
    logic [CW-1:0]          tick_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   bit_done;
    logic                   line;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_in_valid),
        .wdata (data_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_in_ready = !fifo_full;
    assign fifo_pop      = (state == IDLE) && !fifo_empty;
    assign bit_done      = tick && (tick_cnt == TICK_END);
    assign tx_busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        line = IDLE_LEVEL;
        case (state)
            START:   line = 1'b0;
            DATA:    line = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line = parity_bit;
`endif
            default: line = IDLE_LEVEL;
        endcase
    end

    // Tx is the registered line level, so the line lags the state by one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            Tx         <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            Tx <= line;
            if (state == IDLE) begin
                if (!fifo_empty) begin
                    shift      <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= ^fifo_rdata;
`endif
                    tick_cnt   <= '0;
                    bit_idx    <= '0;
                    state      <= START;
                end
            end else if (tick) begin
                tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
                if (bit_done) begin
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: state <= STOP;
`endif
                        STOP:    state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: frame-level reference model compared every
// cycle, plus literal bit patterns, latency, drop and reset checks.
module tb_uart_tx_module;

  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic       tick;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       Tx;
  logic       tx_busy;

  int checks;
  int failures;
  bit cmp_en;
  int tick_mode;

  uart_tx_module #(.FIFO_DEPTH(FIFO_DEPTH), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .Tx            (Tx),
    .tx_busy       (tx_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick source: 0 = held low, 1 = every 4 clks, 2 = random
  initial begin
    int phase;
    phase = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        1:       tick = (phase == 0);
        2:       tick = ($urandom_range(0, 2) == 0);
        default: tick = 1'b0;
      endcase
      phase = (phase + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: byte queue plus the list of line levels of the current frame
  logic [7:0] exp_q[$];
  bit         m_active;
  int         m_pos;
  int         m_tcnt;
  logic       m_frame[0:10];
  logic       tx_exp;
  logic       m_line;
  bit         m_pop;
  bit         m_push;
  logic [7:0] m_byte;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_tcnt   = 0;
      tx_exp   = 1'b1;
    end else begin
      m_line = m_active ? m_frame[m_pos] : 1'b1;
      m_pop  = !m_active && (exp_q.size() > 0);
      m_push = data_in_valid && (exp_q.size() < FIFO_DEPTH);
      if (m_active && tick) begin
        m_tcnt++;
        if (m_tcnt == 16) begin
          m_tcnt = 0;
          m_pos++;
          if (m_pos == NBITS) m_active = 1'b0;
        end
      end
      if (m_pop) begin
        m_byte = exp_q.pop_front();
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[1+i] = m_byte[i];
        if (NBITS == 11) m_frame[9] = ^m_byte;
        m_frame[NBITS-1] = 1'b1;
        m_active = 1'b1;
        m_pos    = 0;
        m_tcnt   = 0;
      end
      if (m_push) exp_q.push_back(data_in);
      tx_exp = m_line;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_tx", {31'd0, Tx}, {31'd0, tx_exp});
      check("cyc_busy", {31'd0, tx_busy}, {31'd0, (m_active || exp_q.size() > 0)});
      check("cyc_ready", {31'd0, data_in_ready}, {31'd0, (exp_q.size() < FIFO_DEPTH)});
    end
  end

  // driver tasks (all start and end at posedge+1)
  task automatic push_byte(input logic [7:0] b);
    data_in = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (tx_busy && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic run_single(input logic [7:0] b, input logic [10:0] exp_bits, input string tag);
    int   ticks;
    int   cyc;
    bit   first;
    logic t;
    logic got[0:10];
    for (int k = 0; k < 11; k++) got[k] = 1'bx;
    tick_mode = 1;
    wait_idle({tag, "_pre_idle"}, 4000);
    push_byte(b);
    @(posedge clk);
    #1;
    check({tag, "_tx_at_pop"}, {31'd0, Tx}, 32'd1);
    ticks = 0;
    cyc   = 0;
    first = 1'b1;
    do begin
      @(posedge clk);
      t = tick;
      #1;
      if (first) begin
        check({tag, "_tx_fall_n2"}, {31'd0, Tx}, 32'd0);
        first = 1'b0;
      end
      if (t) begin
        ticks++;
        if (ticks % 16 == 8 && ticks / 16 < NBITS) got[ticks/16] = Tx;
      end
      cyc++;
    end while (tx_busy && cyc < 4000);
    check({tag, "_busy_end"}, {31'd0, tx_busy}, 32'd0);
    check({tag, "_frame_ticks"}, ticks, NBITS * 16);
    for (int k = 0; k < NBITS; k++)
      check($sformatf("%s_bit%0d", tag, k), {31'd0, got[k]}, {31'd0, exp_bits[k]});
  endtask

  initial begin
    int   acc;
    int   ticks;
    int   cyc;
    logic t;
    checks = 0;
    failures = 0;
    cmp_en = 1'b0;
    tick_mode = 0;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, Tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_ready", {31'd0, data_in_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single bytes with literal bit patterns (bit k at index k)
`ifdef UART_TX_PARITY_EN
    run_single(8'hA5, 11'b10101001010, "a5");
    run_single(8'h00, 11'b10000000000, "zero");
`else
    run_single(8'hA5, 11'b01101001010, "a5");
    run_single(8'h00, 11'b01000000000, "zero");
`endif

    // burst of 6 into an idle block: 5 accepted, 6th sees ready low
    wait_idle("burst_pre_idle", 4000);
    tick_mode = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(8'h30 + i * 17);
      data_in_valid = 1'b1;
      if (i == 5) check("burst_ready_6th", {31'd0, data_in_ready}, 32'd0);
      @(posedge clk);
      if (data_in_ready) acc++;
      #1;
    end
    data_in_valid = 1'b0;
    check("burst_accepted", acc, 5);
    wait_idle("burst_drain", 5 * 176 * 4 + 200);

    // reset mid-frame with bytes still queued
    push_byte(8'h96);
    push_byte(8'h11);
    push_byte(8'h22);
    ticks = 0;
    cyc = 0;
    while (ticks < 72 && cyc < 2000) begin
      @(posedge clk);
      t = tick;
      #1;
      if (t) ticks++;
      cyc++;
    end
    check("midrst_reach_bit3", ticks, 72);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'd0, Tx}, 32'd1);
    check("midrst_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_ready", {31'd0, data_in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
`ifdef UART_TX_PARITY_EN
    run_single(8'h3C, 11'b10001111000, "x3c");
`else
    run_single(8'h3C, 11'b01001111000, "x3c");
`endif

    // stalled tick holds the start bit
    tick_mode = 0;
    push_byte(8'hFF);
    repeat (300) @(posedge clk);
    #1;
    check("stall_tx", {31'd0, Tx}, 32'd0);
    check("stall_busy", {31'd0, tx_busy}, 32'd1);
    tick_mode = 1;
    wait_idle("stall_resume", 2000);

    // randomized traffic with random tick density
    tick_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      data_in = 8'($urandom_range(0, 255));
      data_in_valid = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    data_in_valid = 1'b0;
    wait_idle("random_drain", 12000);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
